// File: rtl/uart_rx_capture_if.sv
// Receive-side stream and status bundle for uart_rx_capture.
// The master modport is the receiver; the slave modport is the byte consumer.
interface uart_rx_capture_if #(
    parameter int Depth = 16
);
    logic [7:0]                 rx_data_o;
    logic                       rx_valid_o;
    logic                       rx_ready_i;
    logic [$clog2(Depth+1)-1:0] level_o;
    logic                       frame_err_o;
    logic                       overflow_o;
    logic                       err_clr_i;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        input  rx_ready_i,
        output level_o,
        output frame_err_o,
        output overflow_o,
        input  err_clr_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        output rx_ready_i,
        input  level_o,
        input  frame_err_o,
        input  overflow_o,
        output err_clr_i
    );
endinterface

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver with a circular output FIFO and sticky error flags.
// The serial line is double-synchronized; frames are sampled at bit centres,
// bytes are buffered and offered on a valid/ready stream.
module uart_rx_capture #(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int Depth          = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    uart_rx_capture_if.master bus
);

    localparam int ClksPerBit = ClockFrequency / BaudRate;
    localparam int CntW       = $clog2(ClksPerBit);
    localparam int PtrW       = $clog2(Depth);
    localparam int LvlW       = $clog2(Depth + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntMid  = CntW'(ClksPerBit / 2 - 1);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);

    generate
        if (ClksPerBit < 4) begin : g_bad_rate
            $error("uart_rx_capture: ClockFrequency/BaudRate must be >= 4");
        end
        if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
            $error("uart_rx_capture: Depth must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    // ------------------------------------------------------------------
    // Line synchronizer
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rxs;

    // Two-flop synchronizer; resets to the idle (high) line level.
    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rxs = sync_q[1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push;
    logic            frame_set;

    // State, bit-timing counter, bit index and shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: sample mid start bit, then once per bit period.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CntMid) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A high line at mid start bit is a glitch, not a frame.
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CntLast) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                // Wait out a held-low line so it reports only one error.
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [7:0]      mem [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q;
    logic            full, pop, wr_en, ovf_set;

    assign full    = (level_q == LvlFull);
    assign pop     = bus.rx_valid_o & bus.rx_ready_i;
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    // Storage write port.
    // NOTE: the array is deliberately not reset; emptiness is tracked by the
    // level counter and the read data is gated while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    // Pointers wrap naturally at Depth; level tracks push/pop balance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_q + LvlW'(wr_en) - LvlW'(pop);
        end
    end

    assign bus.rx_valid_o = (level_q != '0);
    assign bus.rx_data_o  = bus.rx_valid_o ? mem[rd_ptr_q] : 8'h00;
    assign bus.level_o    = level_q;

    // ------------------------------------------------------------------
    // Sticky status flags
    // ------------------------------------------------------------------
    logic frame_err_q, overflow_q;

    // Set events take priority over a coincident clear request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err_q <= 1'b1;
            end else if (bus.err_clr_i) begin
                frame_err_q <= 1'b0;
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.frame_err_o = frame_err_q;
    assign bus.overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Self-checking bench for uart_rx_capture at 16 clocks per bit, Depth 4.
module tb_uart_rx_capture;

    localparam int ClkHz  = 160;
    localparam int Baud   = 10;
    localparam int Depth  = 4;
    localparam int BitClk = ClkHz / Baud;

    logic clk = 1'b0;
    logic rst_i;
    logic rx_i;

    uart_rx_capture_if #(.Depth(Depth)) bus ();

    uart_rx_capture #(
        .ClockFrequency(ClkHz),
        .BaudRate      (Baud),
        .Depth         (Depth)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .rx_i (rx_i),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance n clocks and land 1 ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        tick(BitClk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_bit);
        rx_i = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (bus.rx_valid_o !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_valid_timeout"}, 32'(bus.rx_valid_o), 32'd1);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        check({name, "_valid"}, 32'(bus.rx_valid_o), 32'd1);
        check({name, "_data"},  32'(bus.rx_data_o),  32'(exp));
        bus.rx_ready_i = 1'b1;
        tick(1);
        bus.rx_ready_i = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.err_clr_i = 1'b1;
        tick(1);
        bus.err_clr_i = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_data;
        logic [2:0] exp_level;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, exp_data: 8'hA5, exp_level: 3'd1, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h00, exp_data: 8'h00, exp_level: 3'd1, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'hFF, exp_data: 8'hFF, exp_level: 3'd1, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'h80, exp_data: 8'h80, exp_level: 3'd1, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'h01, exp_data: 8'h01, exp_level: 3'd1, exp_ferr: 1'b0};

        rst_i          = 1'b1;
        rx_i           = 1'b1;
        bus.rx_ready_i = 1'b0;
        bus.err_clr_i  = 1'b0;
        tick(3);
        rst_i = 1'b0;
        tick(2);

        // Reset state
        check("rst_valid", 32'(bus.rx_valid_o),  32'd0);
        check("rst_level", 32'(bus.level_o),     32'd0);
        check("rst_data",  32'(bus.rx_data_o),   32'd0);
        check("rst_ferr",  32'(bus.frame_err_o), 32'd0);
        check("rst_ovf",   32'(bus.overflow_o),  32'd0);

        // Single frames from the vector table, popped one at a time
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, 1'b1);
            wait_valid($sformatf("vec%0d", i), 4 * BitClk);
            tick(2);
            check($sformatf("vec%0d_level", i), 32'(bus.level_o),     32'(vecs[i].exp_level));
            check($sformatf("vec%0d_ferr", i),  32'(bus.frame_err_o), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_ovf", i),   32'(bus.overflow_o),  32'd0);
            pop_expect($sformatf("vec%0d", i), vecs[i].exp_data);
            check($sformatf("vec%0d_empty_valid", i), 32'(bus.rx_valid_o), 32'd0);
            check($sformatf("vec%0d_empty_level", i), 32'(bus.level_o),    32'd0);
            tick(5);
        end

        // Pop while empty is ignored
        bus.rx_ready_i = 1'b1;
        tick(3);
        bus.rx_ready_i = 1'b0;
        check("empty_pop_level", 32'(bus.level_o), 32'd0);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(4);
        check("b2b_level", 32'(bus.level_o),     32'd4);
        check("b2b_ferr",  32'(bus.frame_err_o), 32'd0);
        check("b2b_ovf",   32'(bus.overflow_o),  32'd0);
        pop_expect("b2b0", 8'h00);
        pop_expect("b2b1", 8'hFF);
        pop_expect("b2b2", 8'h55);
        pop_expect("b2b3", 8'h3C);
        check("b2b_empty", 32'(bus.level_o), 32'd0);
        tick(10);

        // Overflow: five frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            tick(3);
        end
        check("ovf_level", 32'(bus.level_o),    32'd4);
        check("ovf_flag",  32'(bus.overflow_o), 32'd1);
        pop_expect("ovf0", 8'h01);
        pop_expect("ovf1", 8'h02);
        pop_expect("ovf2", 8'h03);
        pop_expect("ovf3", 8'h04);
        check("ovf_empty",  32'(bus.level_o),    32'd0);
        check("ovf_sticky", 32'(bus.overflow_o), 32'd1);
        pulse_clear();
        check("ovf_cleared", 32'(bus.overflow_o), 32'd0);
        tick(10);

        // Framing error, then a long break that must not re-flag
        send_frame(8'h7E, 1'b0);
        rx_i = 1'b0;
        tick(5);
        check("ferr_set",   32'(bus.frame_err_o), 32'd1);
        check("ferr_level", 32'(bus.level_o),     32'd0);
        pulse_clear();
        check("ferr_cleared", 32'(bus.frame_err_o), 32'd0);
        tick(34);
        check("ferr_break_once", 32'(bus.frame_err_o), 32'd0);
        rx_i = 1'b1;
        tick(2 * BitClk);
        send_frame(8'h11, 1'b1);
        wait_valid("ferr_next", 4 * BitClk);
        tick(2);
        check("ferr_next_level", 32'(bus.level_o),     32'd1);
        check("ferr_next_ferr",  32'(bus.frame_err_o), 32'd0);
        pop_expect("ferr_next", 8'h11);
        tick(10);

        // Glitch shorter than half a bit is rejected
        rx_i = 1'b0;
        tick(4);
        rx_i = 1'b1;
        tick(3 * BitClk);
        check("glitch_valid", 32'(bus.rx_valid_o),  32'd0);
        check("glitch_level", 32'(bus.level_o),     32'd0);
        check("glitch_ferr",  32'(bus.frame_err_o), 32'd0);
        check("glitch_ovf",   32'(bus.overflow_o),  32'd0);

        // Reset mid-frame discards both the FIFO contents and the partial byte
        send_frame(8'h99, 1'b1);
        tick(3);
        check("pre_rst_level", 32'(bus.level_o), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rx_i = 1'b0;
        tick(BitClk / 2);
        rx_i  = 1'b1;
        rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        tick(2 * BitClk);
        check("midrst_level", 32'(bus.level_o),    32'd0);
        check("midrst_valid", 32'(bus.rx_valid_o), 32'd0);
        check("midrst_data",  32'(bus.rx_data_o),  32'd0);
        send_frame(8'h5A, 1'b1);
        tick(3);
        check("midrst_next_level", 32'(bus.level_o),     32'd1);
        check("midrst_next_ferr",  32'(bus.frame_err_o), 32'd0);
        pop_expect("midrst_next", 8'h5A);
        check("midrst_final_level", 32'(bus.level_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Synthesizable 8N1 UART receiver with an output FIFO.
- Used in the Verilator top as the capture end of the demo system's uart_tx_o line, as the counterpart to the system's transmitter.
- Deserializes frames, buffers bytes, and presents them on a valid/ready stream.
- Flags framing errors and FIFO overflow with sticky status bits.

Parameters:
- ClockFrequency, 50_000_000, clk_i frequency in Hz.
- BaudRate, 115_200, line rate in bit/s. ClksPerBit = ClockFrequency/BaudRate, integer-truncated, must be >= 4 (elaboration assertion).
- Depth, 16, FIFO entries. Power of two, >= 2.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- rx_i  in  1  serial line, idle high, asynchronous to clk_i
- rx_data_o  out  8  byte at FIFO head
- rx_valid_o  out  1  FIFO non-empty
- rx_ready_i  in  1  consumer pop; a pop occurs when valid & ready
- level_o  out  $clog2(Depth+1)  FIFO occupancy
- frame_err_o  out  1  sticky: a stop bit sampled as 0
- overflow_o  out  1  sticky: a byte was dropped because the FIFO was full
- err_clr_i  in  1  clears both sticky flags

Behaviour:
- Reset (rst_i high at a clock edge):
  - All outputs 0; FIFO empty; state IDLE.
  - Synchronizer flops reset to 1.
  - Reset mid-frame discards the partial byte.
- rx_i passes through a 2-flop synchronizer; rxs denotes the synchronized value. All decisions use rxs.
- Bit counter: 0..ClksPerBit-1. Bit index: 0..7.
- FSM:
  - IDLE: when rxs == 0, go to START with counter = 0.
  - START: count to ClksPerBit/2 - 1 (mid start bit), then sample rxs.
    - 0 → DATA, counter = 0, index = 0.
    - 1 → IDLE (glitch rejected; no flag).
  - DATA: on each counter == ClksPerBit-1, sample rxs into shift[index] (LSB first), reset counter, increment index. After index 7 is sampled → STOP.
  - STOP: at counter == ClksPerBit-1, sample rxs.
    - 1 → push byte, go to IDLE.
    - 0 → set frame_err_o, no push, go to BREAK.
  - BREAK: stay until rxs == 1, then go to IDLE. A held-low line produces exactly one frame error.
- Push timing:
  - The byte is written on the stop-sample edge.
  - rx_valid_o and level_o update on the following cycle (registered FIFO).
  - rx_i-to-rx_valid_o latency is about 9.5 bit times + 3 clocks.
- FIFO:
  - Circular buffer. Pointers are $clog2(Depth) bits and wrap naturally.
  - rx_data_o = mem[rd_ptr] whenever rx_valid_o = 1; it is don't-care when empty.
  - Pop when empty: ignored.
  - Push when level == Depth with no pop in the same cycle: byte dropped, overflow_o set, FIFO unchanged.
  - Push and pop in the same cycle when full: both occur; level stays Depth; no overflow.
  - Push and pop in the same cycle when non-empty: level unchanged.
- Sticky flags:
  - err_clr_i clears both flags the next cycle.
  - If a set event and err_clr_i coincide, set wins.
- Back-to-back frames: a start bit beginning immediately after the stop-bit midpoint is detected (IDLE is re-entered mid stop bit).

Test Plan (ClockFrequency=160, BaudRate=10, so ClksPerBit=16; Depth=4):
- Single byte: send 0xA5 as 8N1 with rx_ready_i=0 → rx_valid_o=1, rx_data_o=0xA5, level_o=1, no flags. Pulse rx_ready_i one cycle → rx_valid_o=0, level_o=0.
- Back-to-back: send 0x00, 0xFF, 0x55, 0x3C with no idle gap → popped in order 0x00, 0xFF, 0x55, 0x3C; frame_err_o=0.
- Overflow: send 5 bytes 0x01..0x05 with ready=0 → level_o=4, overflow_o=1, pops yield 0x01..0x04. Assert err_clr_i → overflow_o=0.
- Framing: send 0x7E with stop bit 0, then hold low 40 clocks, then high → frame_err_o=1, level_o=0. Next valid 0x11 is received correctly.
- Glitch: drive rx_i low for 4 clocks, then high → state returns to IDLE, no push, no flags.
- Reset mid-frame: assert rst_i during bit 3 of 0xC3, release, then send 0x5A → only 0x5A is received, level_o=1.
